vblank_update_arbiter: RTL

Shares the single game-object-state update port (ball, paddles, score) between `N_REQ` requesters, and only lets them use it during vertical blanking. It watches the `display_ctrl` pixel coordinates, opens an update window each frame, and issues one-hot round-robin grants with a req/grant/done handshake and a per-grant timeout. It sits between `display_ctrl` and the `pingpong` object logic, so renderers never read half-updated state.

---
 rtl/vblank_update_arbiter_pkg.sv | 21 ++
 rtl/vblank_update_arbiter_if.sv | 27 ++
 rtl/vblank_update_arbiter_rr_pick.sv | 38 +++
 rtl/vblank_update_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/vblank_update_arbiter_pkg.sv
// Shared types and default frame geometry for the vblank update arbiter.
// The FSM enum is exported so debug ports and benches can decode state.
package vblank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2
  } state_t;

  localparam int DEF_V_ACTIVE = 600;
  localparam int DEF_V_TOTAL  = 625;
  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_TOTAL  = 1024;

  // Increment an index, wrapping back to zero at n.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vblank_update_arbiter_if.sv
// Bundle of coordinates, requester handshake and window/status signals.
// Handshake: req is a level held by a requester; grant is one-hot while it owns
// the port; the owner answers with a one-cycle done pulse, after which grant drops.
interface vblank_update_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [10:0]      h_coord;
  logic [9:0]       v_coord;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] grant;
  logic             frame_start;
  logic             window_open;
  logic             busy;
  logic             timeout;
  logic [N_REQ-1:0] missed;

  modport master (
    output h_coord, v_coord, req, done,
    input  grant, frame_start, window_open, busy, timeout, missed
  );

  modport slave (
    input  h_coord, v_coord, req, done,
    output grant, frame_start, window_open, busy, timeout, missed
  );
endinterface

// File: rtl/vblank_update_arbiter_rr_pick.sv
// Combinational round-robin find-first: first set bit of cand_i at or above
// ptr_i, wrapping. Returns the winner one-hot and as an index.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  cand_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] j;

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    found    = 1'b0;
    sum      = '0;
    j        = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (PW+1)'(k);
      if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      j = sum[PW-1:0];
      if (!found && cand_i[j]) begin
        found       = 1'b1;
        valid_o     = 1'b1;
        onehot_o[j] = 1'b1;
        idx_o       = j;
      end
    end
  end

endmodule

// File: rtl/vblank_update_arbiter.sv
// Grants the shared object-state update port to one requester at a time, only
// inside the vertical-blanking window, round-robin, at most once per frame.
module vblank_update_arbiter
  import vblank_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int GUARD_LINES = 2,
  parameter int MAX_CYCLES  = 256
) (
  input  logic                    pixel_clk,
  input  logic                    rst,
  vblank_update_arbiter_if.slave  bus,
  output state_t                  dbg_state_o
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] served_q, served_d;
  logic [N_REQ-1:0] missed_q, missed_d;
  logic [CW-1:0]    tcnt_q, tcnt_d;
  logic             win_q, win_d;
  logic             fs_q;
  logic             to_q, to_d;

  logic             coord_match, guard_hit, done_hit, to_hit;
  logic [N_REQ-1:0] pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;

  assign coord_match = (bus.v_coord == 10'(V_ACTIVE)) && (bus.h_coord == '0);
  assign guard_hit   = (bus.v_coord == 10'(V_TOTAL - GUARD_LINES));
  assign done_hit    = |(bus.done & grant_q);
  assign to_hit      = (tcnt_q == CW'(MAX_CYCLES - 1));

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .cand_i   (bus.req & ~served_q),
    .ptr_i    (ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .valid_o  (pick_valid)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    tcnt_d   = tcnt_q;
    to_d     = 1'b0;
    served_d = coord_match ? '0 : served_q;
    missed_d = coord_match ? (bus.req & ~served_q) : '0;
    win_d    = coord_match ? 1'b1 : (guard_hit ? 1'b0 : win_q);
    unique case (state_q)
      ST_IDLE: begin
        if (win_d) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (!win_q) begin
          state_d = ST_IDLE;
        end else if (pick_valid) begin
          state_d = ST_GRANT;
          owner_d = pick_idx;
          grant_d = pick_onehot;
          tcnt_d  = '0;
        end
      end
      ST_GRANT: begin
        // A completing owner marks the mask after any frame-start clear above.
        if (done_hit || to_hit) begin
          served_d = served_d | grant_q;
          ptr_d    = PW'(wrap_inc(int'(owner_q), N_REQ));
          to_d     = !done_hit;
          state_d  = win_q ? ST_ARB : ST_IDLE;
        end else begin
          tcnt_d = tcnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      grant_q  <= '0;
      served_q <= '0;
      missed_q <= '0;
      tcnt_q   <= '0;
      win_q    <= 1'b0;
      fs_q     <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      grant_q  <= grant_d;
      served_q <= served_d;
      missed_q <= missed_d;
      tcnt_q   <= tcnt_d;
      win_q    <= win_d;
      fs_q     <= coord_match;
      to_q     <= to_d;
    end
  end

  assign bus.grant       = (state_q == ST_GRANT) ? grant_q : '0;
  assign bus.busy        = (state_q == ST_GRANT);
  assign bus.frame_start = fs_q;
  assign bus.window_open = win_q;
  assign bus.timeout     = to_q;
  assign bus.missed      = missed_q;
  assign dbg_state_o     = state_q;

endmodule
